// File: rtl/btn_debounce.sv
// Multi-channel push-button debouncer: two-flop synchronizer per bit, then a per-channel
// FSM that accepts a level change only after CNT_MAX consecutive deviating samples.
module btn_debounce #(
   parameter int unsigned N       = 4,
   parameter int unsigned CNT_MAX = 12000
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [N-1:0] BTN_IN,
   output logic [N-1:0] BTN,
   output logic [N-1:0] PRESS,
   output logic [N-1:0] RELEASE
);

   localparam int unsigned CW = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] CntLast  = CW'(CNT_MAX - 1);
   // With CNT_MAX == 1 the count must stay at 0 so it never exceeds CNT_MAX-1.
   localparam logic [CW-1:0] CntFirst = (CNT_MAX > 1) ? CW'(1) : CW'(0);

   typedef enum logic [1:0] {
      StIdleLo,
      StWaitHi,
      StIdleHi,
      StWaitLo
   } state_e;

   logic [N-1:0] s1_q;
   logic [N-1:0] s2_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= BTN_IN;
         s2_q <= s1_q;
      end
   end

   for (genvar g = 0; g < N; g++) begin : gen_chan
      state_e        state_q;
      logic [CW-1:0] cnt_q;
      logic          stable_q;
      logic          press_q;
      logic          release_q;

      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            state_q   <= StIdleLo;
            cnt_q     <= '0;
            stable_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state_q)
               StIdleLo, StIdleHi: begin
                  cnt_q <= '0;
                  if (s2_q[g] != stable_q) begin
                     state_q <= stable_q ? StWaitLo : StWaitHi;
                     cnt_q   <= CntFirst;
                  end
               end
               StWaitHi, StWaitLo: begin
                  if (s2_q[g] == stable_q) begin
                     // Bounce back to the accepted level: abandon this attempt.
                     cnt_q   <= '0;
                     state_q <= stable_q ? StIdleHi : StIdleLo;
                  end else if (cnt_q >= CntLast) begin
                     cnt_q     <= '0;
                     stable_q  <= ~stable_q;
                     state_q   <= stable_q ? StIdleLo : StIdleHi;
                     press_q   <= ~stable_q;
                     release_q <= stable_q;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end
               default: begin
                  state_q <= StIdleLo;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign BTN[g]     = stable_q;
      assign PRESS[g]   = press_q;
      assign RELEASE[g] = release_q;
   end

endmodule
